// File: rtl/guess_generator.sv
// guess_generator
//   Enumerates candidate words over the alphabet CHAR_MIN..CHAR_MAX for a
//   brute-force search. The last character (word[7:0]) steps by a per-core
//   increment from a per-core starting value, so several cores can split the
//   keyspace. Higher positions count as an odometer. The word length grows
//   from 1 to MAX_LEN characters.
//
// Handshake: valid is high in RUN. A word is transferred on every rising
//   clock edge where valid && ready. word/word_width stay stable while
//   valid && !ready, and the next word follows with no bubble.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   start            1-cycle pulse: latch config, begin enumeration (IDLE/DONE only)
//   stop             abort: go to IDLE, hold word/word_width/count
//   startingPosition first value of the last character
//   increment        step of the last character (0 is treated as 1)
//   ready            downstream accepts the current word
//   valid            word/word_width are valid
//   word             right-aligned ASCII guess, unused upper bytes zero
//   word_width       guess length in bits
//   busy             high in RUN
//   exhausted        keyspace finished
//   count            words transferred since the last start
//   dbg_state        FSM state (0 IDLE, 1 RUN, 2 DONE)
module guess_generator #(
   parameter int         MAX_LEN  = 6,
   parameter logic [7:0] CHAR_MIN = 8'h61,
   parameter logic [7:0] CHAR_MAX = 8'h7a
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic [7:0]   startingPosition,
   input  logic [2:0]   increment,
   input  logic         ready,
   output logic         valid,
   output logic [127:0] word,
   output logic [7:0]   word_width,
   output logic         busy,
   output logic         exhausted,
   output logic [31:0]  count,
   output logic [1:0]   dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [7:0] chars [MAX_LEN];
   logic [7:0] nxt   [MAX_LEN];
   logic [4:0] len;
   logic [7:0] start_lat;
   logic [2:0] inc_lat;
   logic [7:0] start_sel;
   logic [2:0] inc_sel;
   logic [8:0] sum;
   logic       carry;
   logic       carry_out;
   logic       xfer;

   // Sanitised configuration, applied only when it is latched.
   assign start_sel = (startingPosition < CHAR_MIN || startingPosition > CHAR_MAX)
                      ? CHAR_MIN : startingPosition;
   assign inc_sel   = (increment == 3'd0) ? 3'd1 : increment;

   assign valid      = (state == RUN);
   assign busy       = (state == RUN);
   assign xfer       = valid && ready;
   assign dbg_state  = state;
   assign word_width = {len, 3'b000};

   // Next word. Position 0 adds the increment at 9 bits so an overflow past
   // CHAR_MAX is seen directly. Higher positions ripple +1 only while a carry
   // is pending. A carry that leaves the top used position sets the next
   // position to CHAR_MIN. Positions below it already hold their reload value.
   always_comb begin
      carry = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) nxt[i] = chars[i];
      sum = {1'b0, chars[0]} + {6'b0, inc_lat};
      if (sum > {1'b0, CHAR_MAX}) begin
         nxt[0] = start_lat;
         carry  = 1'b1;
      end else begin
         nxt[0] = sum[7:0];
      end
      for (int i = 1; i < MAX_LEN; i++) begin
         if (carry && i < int'(len)) begin
            sum = {1'b0, chars[i]} + 9'd1;
            if (sum > {1'b0, CHAR_MAX}) begin
               nxt[i] = CHAR_MIN;
            end else begin
               nxt[i] = sum[7:0];
               carry  = 1'b0;
            end
         end
      end
      carry_out = carry;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (carry && i == int'(len)) nxt[i] = CHAR_MIN;
      end
   end

   always_comb begin
      word = '0;
      for (int i = 0; i < MAX_LEN; i++) word[8*i +: 8] = chars[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         len       <= '0;
         start_lat <= CHAR_MIN;
         inc_lat   <= 3'd1;
         count     <= '0;
         exhausted <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) chars[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  start_lat <= start_sel;
                  inc_lat   <= inc_sel;
                  count     <= '0;
                  exhausted <= 1'b0;
                  len       <= 5'd1;
                  for (int i = 0; i < MAX_LEN; i++) chars[i] <= '0;
                  chars[0]  <= start_sel;
               end
            end
            RUN: begin
               if (xfer) count <= count + 32'd1;
               if (stop) begin
                  // A transfer in this cycle is counted, but the word is frozen.
                  state <= IDLE;
               end else if (xfer) begin
                  if (carry_out && len == 5'(MAX_LEN)) begin
                     state     <= DONE;
                     exhausted <= 1'b1;
                  end else begin
                     for (int i = 0; i < MAX_LEN; i++) chars[i] <= nxt[i];
                     len <= len + {4'b0, carry_out};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_generator.sv
// tb_guess_generator
//   Directed-vector bench for guess_generator, built with MAX_LEN=2. It covers
//   reset values, the full 2-character keyspace, stepping the last character
//   by 3, a ready stall, stop, an asynchronous reset in RUN, and config
//   sanitising.
module tb_guess_generator;

   logic         clk;
   logic         reset;
   logic         start;
   logic         stop;
   logic [7:0]   startingPosition;
   logic [2:0]   increment;
   logic         ready;
   logic         valid;
   logic [127:0] word;
   logic [7:0]   word_width;
   logic         busy;
   logic         exhausted;
   logic [31:0]  count;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   guess_generator #(.MAX_LEN(2), .CHAR_MIN(8'h61), .CHAR_MAX(8'h7a)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .stop             (stop),
      .startingPosition (startingPosition),
      .increment        (increment),
      .ready            (ready),
      .valid            (valid),
      .word             (word),
      .word_width       (word_width),
      .busy             (busy),
      .exhausted        (exhausted),
      .count            (count),
      .dbg_state        (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checking
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drivers: inputs change 1 ns after the rising edge, outputs are sampled there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] pos, input logic [2:0] inc);
      startingPosition = pos;
      increment        = inc;
      start            = 1'b1;
      tick();
      start            = 1'b0;
   endtask

   logic [127:0] exp_w;
   logic [7:0]   seq_b3 [9];
   logic [7:0]   ch;

   initial begin
      seq_b3 = '{8'h62, 8'h65, 8'h68, 8'h6b, 8'h6e, 8'h71, 8'h74, 8'h77, 8'h7a};
      reset = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
      startingPosition = 8'h00; increment = 3'd0;
      tick(); tick();

      check("rst_valid", {127'b0, valid}, 128'd0);
      check("rst_busy", {127'b0, busy}, 128'd0);
      check("rst_exhausted", {127'b0, exhausted}, 128'd0);
      check("rst_word", word, 128'd0);
      check("rst_width", {120'b0, word_width}, 128'd0);
      check("rst_count", {96'b0, count}, 128'd0);
      check("rst_state", {126'b0, dbg_state}, 128'd0);
      reset = 1'b1;
      tick();

      // Full keyspace with MAX_LEN=2: a..z, then aa..zz, 702 words.
      // A start pulse with a different config during RUN must be ignored.
      ready = 1'b1;
      do_start(8'h61, 3'd1);
      check("run_busy", {127'b0, busy}, 128'd1);
      for (int n = 0; n < 702; n++) begin
         exp_w = '0;
         if (n < 26) begin
            exp_w[7:0] = 8'(97 + n);
         end else begin
            exp_w[15:8] = 8'(97 + (n - 26) / 26);
            exp_w[7:0]  = 8'(97 + (n - 26) % 26);
         end
         check("full_word", word, exp_w);
         if (n == 0)  check("full_width1", {120'b0, word_width}, 128'd8);
         if (n == 26) check("full_width2", {120'b0, word_width}, 128'd16);
         if (n == 100) check("full_count", {96'b0, count}, 128'd100);
         if (n == 5) begin
            startingPosition = 8'h6d;
            increment        = 3'd4;
            start            = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      check("done_valid", {127'b0, valid}, 128'd0);
      check("done_busy", {127'b0, busy}, 128'd0);
      check("done_exhausted", {127'b0, exhausted}, 128'd1);
      check("done_count", {96'b0, count}, 128'd702);
      check("done_state", {126'b0, dbg_state}, 128'd2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("done_stop_ign", {126'b0, dbg_state}, 128'd2);
      check("done_hold_count", {96'b0, count}, 128'd702);

      // Start 'b', step 3: b e h k n q t w z, then "ab", then "ae"
      do_start(8'h62, 3'd3);
      check("b3_exhausted", {127'b0, exhausted}, 128'd0);
      for (int n = 0; n < 9; n++) begin
         check("b3_word", word, {120'b0, seq_b3[n]});
         check("b3_width", {120'b0, word_width}, 128'd8);
         tick();
      end
      check("b3_ab", word, 128'h6162);
      check("b3_ab_width", {120'b0, word_width}, 128'd16);
      check("b3_ab_count", {96'b0, count}, 128'd9);

      // ready 1-0-0-1
      tick();
      check("stall_ae", word, 128'h6165);
      check("stall_cnt0", {96'b0, count}, 128'd10);
      ready = 1'b0;
      tick();
      check("stall_hold1", word, 128'h6165);
      check("stall_cnt1", {96'b0, count}, 128'd10);
      tick();
      check("stall_hold2", word, 128'h6165);
      check("stall_cnt2", {96'b0, count}, 128'd10);
      check("stall_valid", {127'b0, valid}, 128'd1);
      ready = 1'b1;
      tick();
      check("stall_ah", word, 128'h6168);
      check("stall_cnt3", {96'b0, count}, 128'd11);

      // Stop without a transfer
      ready = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      check("stop0_valid", {127'b0, valid}, 128'd0);
      check("stop0_word", word, 128'h6168);
      check("stop0_count", {96'b0, count}, 128'd11);

      // Stop with ready while word is "c": "c" is counted and held
      ready = 1'b1;
      do_start(8'h61, 3'd1);
      tick(); tick();
      check("stop_pre_c", word, 128'h63);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_count", {96'b0, count}, 128'd3);
      check("stop_valid", {127'b0, valid}, 128'd0);
      check("stop_busy", {127'b0, busy}, 128'd0);
      check("stop_word", word, 128'h63);
      check("stop_width", {120'b0, word_width}, 128'd8);
      check("stop_state", {126'b0, dbg_state}, 128'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("idle_stop_count", {96'b0, count}, 128'd3);
      check("idle_stop_word", word, 128'h63);

      // Carry from the last character with step 7: 'y'+7 overflows to "ay"
      do_start(8'h79, 3'd7);
      check("y7_first", word, 128'h79);
      tick();
      check("y7_carry", word, 128'h6179);
      check("y7_width", {120'b0, word_width}, 128'd16);

      // Asynchronous reset during a transfer
      #2;
      reset = 1'b0;
      #1;
      check("areset_valid", {127'b0, valid}, 128'd0);
      check("areset_busy", {127'b0, busy}, 128'd0);
      check("areset_word", word, 128'd0);
      check("areset_width", {120'b0, word_width}, 128'd0);
      check("areset_count", {96'b0, count}, 128'd0);
      tick();
      reset = 1'b1;
      tick();

      // Out-of-range start and zero increment: "a" with step 1
      do_start(8'h20, 3'd0);
      check("san_a", word, 128'h61);
      tick();
      check("san_b", word, 128'h62);
      check("san_count1", {96'b0, count}, 128'd1);
      tick();
      check("san_c", word, 128'h63);
      check("san_count2", {96'b0, count}, 128'd2);

      // A start value above CHAR_MAX is also replaced by CHAR_MIN
      ready = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      do_start(8'h7b, 3'd2);
      ch = word[7:0];
      check("san_hi_start", {120'b0, ch}, 128'h61);
      ready = 1'b1;
      tick();
      check("san_hi_step", word, 128'h63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
